ezm_cpu_gen2: RTL

Parametrised second-generation accumulator CPU for the 8-bit tile I/O budget. Instructions arrive one at a time on a 6-bit input bus, and execution alternates between two phases: FETCH and EXEC. Compared with the first generation it adds a configurable data width and register count, a carry flag, shift and carry-branch instructions, HALT, and a fully registered output. It sits directly under the tile wrapper, which maps clk, rst, in_i and out_o onto the tile pins.

---
 rtl/ezm_cpu_pkg.sv | 56 +++++
 rtl/ezm_cpu_gen2_if.sv | 18 +
 rtl/ezm_regbank.sv | 29 ++
 rtl/ezm_cpu_gen2.sv | 103 ++++++++++
 4 files changed

// File: rtl/ezm_cpu_pkg.sv
// ezm_cpu_pkg: shared definitions for the ezm_cpu_gen2 accumulator CPU.
//   - phase encoding (PH_FETCH / PH_EXEC)
//   - opcode constants (prefixes for the register-indexed groups, full
//     6-bit words for the single-word group)
//   - decode_op(): first-match instruction decoder used by the top level
package ezm_cpu_pkg;

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_e;

    // 1iiiii: LOAD with 5-bit signed immediate
    localparam logic       OP_LOAD = 1'b1;
    // xxx rrr: register-indexed groups, matched on ir[5:3]
    localparam logic [2:0] OP_BGT  = 3'b011;
    localparam logic [2:0] OP_STA  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    // 000xxx: single-word instructions
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_NOT  = 6'b000001;
    localparam logic [5:0] OP_SHL  = 6'b000010;
    localparam logic [5:0] OP_SHR  = 6'b000011;
    localparam logic [5:0] OP_CLC  = 6'b000100;
    localparam logic [5:0] OP_SEC  = 6'b000101;
    localparam logic [5:0] OP_BCS  = 6'b000110;
    localparam logic [5:0] OP_HALT = 6'b000111;

    typedef enum logic [3:0] {
        I_LOAD, I_BGT, I_STA, I_ADD, I_NOP, I_NOT,
        I_SHL, I_SHR, I_CLC, I_SEC, I_BCS, I_HALT
    } instr_e;

    // First match wins: LOAD, then the register groups, then 000xxx.
    function automatic instr_e decode_op(input logic [5:0] ir);
        instr_e op;
        if (ir[5] == OP_LOAD)         op = I_LOAD;
        else if (ir[5:3] == OP_BGT)   op = I_BGT;
        else if (ir[5:3] == OP_STA)   op = I_STA;
        else if (ir[5:3] == OP_ADD)   op = I_ADD;
        else begin
            case (ir)
                OP_NOP:  op = I_NOP;
                OP_NOT:  op = I_NOT;
                OP_SHL:  op = I_SHL;
                OP_SHR:  op = I_SHR;
                OP_CLC:  op = I_CLC;
                OP_SEC:  op = I_SEC;
                OP_BCS:  op = I_BCS;
                default: op = I_HALT;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/ezm_cpu_gen2_if.sv
// ezm_cpu_gen2_if: tile-side bus of the CPU.
//   in_i     instruction word (driven by the tile, sampled only on FETCH)
//   out_o    registered acc/pc view
//   phase_o  current phase (0 = next edge is FETCH)
//   halted_o sticky HALT indication
// There is no valid/ready handshake: the tile owns in_i and the CPU
// consumes it on every FETCH edge, so phase_o is the only pacing signal.
interface ezm_cpu_gen2_if #(
    parameter int OUT_W = 8
);
    logic [5:0]       in_i;
    logic [OUT_W-1:0] out_o;
    logic             phase_o;
    logic             halted_o;

    modport master (output in_i, input  out_o, phase_o, halted_o);
    modport slave  (input  in_i, output out_o, phase_o, halted_o);
endinterface

// File: rtl/ezm_regbank.sv
// ezm_regbank: NREG x DATA_W register bank.
//   clk, rst  clock, asynchronous active-high reset (all registers to 0)
//   rd_idx    combinational read address -> rd_data
//   wr_en     synchronous write enable, wr_idx / wr_data
module ezm_regbank #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int IDX_W  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data
);
    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign rd_data = regs[rd_idx];
endmodule

// File: rtl/ezm_cpu_gen2.sv
// ezm_cpu_gen2: two-phase accumulator CPU (FETCH / EXEC).
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of ezm_cpu_gen2_if:
//        in_i (instruction), out_o (acc after FETCH, pc after EXEC),
//        phase_o (phase FSM state), halted_o (sticky halt)
module ezm_cpu_gen2
    import ezm_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int PC_W   = 8,
    parameter int OUT_W  = 8
) (
    input logic           clk,
    input logic           rst,
    ezm_cpu_gen2_if.slave bus
);
    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int XW    = (DATA_W > PC_W) ? DATA_W : PC_W;

    phase_e            phase;
    logic [5:0]        ir;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [PC_W-1:0]   pc, pc_nxt;
    logic              carry, carry_nxt;
    logic              halted, halt_nxt;
    logic              sta_en;
    logic [OUT_W-1:0]  out_q;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W:0]   sum;
    logic [XW-1:0]     acc_wide, pc_wide;

    ezm_regbank #(.DATA_W(DATA_W), .NREG(NREG), .IDX_W(IDX_W)) u_bank (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (ir[IDX_W-1:0]),
        .rd_data (rd_data),
        .wr_en   (sta_en && (phase == PH_EXEC)),
        .wr_idx  (ir[IDX_W-1:0]),
        .wr_data (acc)
    );

    assign sum = {1'b0, acc} + {1'b0, rd_data};

    // Next architectural state for the EXEC edge. While halted every
    // value holds, so the EXEC edge re-publishes the frozen pc.
    always_comb begin
        acc_nxt   = acc;
        pc_nxt    = pc;
        carry_nxt = carry;
        halt_nxt  = halted;
        sta_en    = 1'b0;
        if (!halted) begin
            pc_nxt = pc + PC_W'(1);
            case (decode_op(ir))
                I_LOAD: acc_nxt = {{(DATA_W-5){ir[4]}}, ir[4:0]};
                I_BGT:  if (rd_data > acc) pc_nxt = pc - PC_W'(acc);
                I_STA:  sta_en = 1'b1;
                I_ADD:  {carry_nxt, acc_nxt} = sum;
                I_NOT:  acc_nxt = ~acc;
                I_SHL:  begin carry_nxt = acc[DATA_W-1]; acc_nxt = acc << 1; end
                I_SHR:  begin carry_nxt = acc[0];        acc_nxt = acc >> 1; end
                I_CLC:  carry_nxt = 1'b0;
                I_SEC:  carry_nxt = 1'b1;
                I_BCS:  if (carry) pc_nxt = pc - PC_W'(acc);
                I_HALT: begin halt_nxt = 1'b1; pc_nxt = pc; end
                default: ;
            endcase
        end
    end

    // Zero-extend to the wider of acc/pc, then keep the low OUT_W bits.
    assign acc_wide = XW'(acc);
    assign pc_wide  = XW'(pc_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= PH_FETCH;
            ir     <= '0;
            acc    <= '0;
            pc     <= '0;
            carry  <= 1'b0;
            halted <= 1'b0;
            out_q  <= '0;
        end else if (phase == PH_FETCH) begin
            if (!halted) ir <= bus.in_i;
            out_q <= acc_wide[OUT_W-1:0];
            phase <= PH_EXEC;
        end else begin
            acc    <= acc_nxt;
            pc     <= pc_nxt;
            carry  <= carry_nxt;
            halted <= halt_nxt;
            out_q  <= pc_wide[OUT_W-1:0];
            phase  <= PH_FETCH;
        end
    end

    assign bus.out_o    = out_q;
    assign bus.phase_o  = phase;
    assign bus.halted_o = halted;
endmodule
